// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I instruction-fetch front end.
package fetch_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        DRAIN
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] pc;
        logic [31:0]             instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO with flush; simultaneous push and pop are both honoured,
// so a full FIFO that pops and pushes in one cycle stays full.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter type         entry_t = fetch_entry_t,
    parameter int unsigned DEPTH   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  entry_t                   push_data,
    input  logic                     pop,
    input  logic                     flush,
    output entry_t                   head,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    entry_t        mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          empty;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: PC ownership, imem requests, response buffering, redirects.
// Optional sticky misaligned-redirect flag enabled by `define FETCH_MISALIGN_CHECK_EN.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [31:0]     if_instr,
    output logic            fetch_misalign
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    fetch_state_t    state;
    fetch_state_t    state_next;
    logic [XLEN-1:0] pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   discard;
    logic [CW-1:0]   discard_next;
    logic [CW-1:0]   rsp_count;
    logic [CW-1:0]   tag_count;
    logic [CW:0]     in_flight;
    logic            accept;
    logic            rsp_seen;
    logic            rsp_keep;
    logic            pop;
    logic [XLEN-1:0] tag_head;
    fetch_entry_t    rsp_head;
    fetch_entry_t    rsp_entry;

    // Responses with nothing outstanding (e.g. stale ones straddling a reset) are ignored.
    assign rsp_seen  = imem_rsp_valid && (outstanding != '0);
    assign rsp_keep  = rsp_seen && (discard == '0) && !redirect_valid && (tag_count != '0);
    assign accept    = imem_req_valid && imem_req_ready;
    assign pop       = if_valid && id_ready;
    assign in_flight = {1'b0, outstanding} + {1'b0, rsp_count};
    assign rsp_entry = '{pc: tag_head, instr: imem_rsp_data};

    assign imem_req_valid = (state == RUN) && (in_flight < (CW+1)'(DEPTH));
    assign imem_addr      = pc;
    assign if_valid       = (rsp_count != '0);
    assign if_pc          = if_valid ? rsp_head.pc : '0;
    assign if_instr       = if_valid ? rsp_head.instr : NOP_INSTR;

    fetch_buffer #(
        .entry_t (logic [XLEN-1:0]),
        .DEPTH   (DEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (accept && !redirect_valid),
        .push_data (pc),
        .pop       (rsp_keep),
        .flush     (redirect_valid),
        .head      (tag_head),
        .count     (tag_count)
    );

    fetch_buffer #(
        .entry_t (fetch_entry_t),
        .DEPTH   (DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rsp_keep),
        .push_data (rsp_entry),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (rsp_head),
        .count     (rsp_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= BOOT;
        else     state <= state_next;
    end

    // One discard formula covers RUN and DRAIN: in DRAIN outstanding equals discard.
    always_comb begin
        state_next   = state;
        discard_next = discard;
        if (redirect_valid) begin
            discard_next = outstanding - CW'(rsp_seen) + CW'(accept);
        end else if (rsp_seen && (discard != '0)) begin
            discard_next = discard - CW'(1);
        end
        unique case (state)
            BOOT:    state_next = RUN;
            RUN,
            DRAIN: begin
                if (redirect_valid) begin
                    state_next = (discard_next != '0) ? DRAIN : RUN;
                end else if ((state == DRAIN) && (discard == '0)) begin
                    state_next = RUN;
                end
            end
            default: state_next = BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            discard     <= discard_next;
            outstanding <= outstanding + CW'(accept) - CW'(rsp_seen);
            if (redirect_valid) pc <= redirect_pc & ~XLEN'(3);
            else if (accept)    pc <= pc + XLEN'(4);
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_misalign <= 1'b0;
        end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
            fetch_misalign <= 1'b1;
        end
    end
`else
    assign fetch_misalign = 1'b0;
`endif

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch front end of the pipelined RV32I core. Sits directly upstream of decode/register-read and produces the {pc, instr} pairs that decode consumes.
- Owns the PC and issues word requests to instruction memory.
- Buffers responses in a small FIFO and hands them to decode with a valid/ready handshake.
- Handles branch/jump redirects from EX, including discarding in-flight stale responses.

Parameters:
XLEN, 32, datapath/PC width
RESET_PC, 32'h0000_0000, first fetch address after reset
DEPTH, 2, fetch buffer entries; also the max outstanding imem requests (power of 2, >=2)

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-high reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request this cycle
imem_addr  out  XLEN  word-aligned fetch address
imem_rsp_valid  in  1  response valid; in order, >=1 cycle after acceptance
imem_rsp_data  in  32  instruction word
redirect_valid  in  1  EX-stage taken branch/jump, one-cycle pulse
redirect_pc  in  XLEN  redirect target
if_valid  out  1  if_pc/if_instr valid toward decode
id_ready  in  1  decode accepts (low = stall)
if_pc  out  XLEN  PC of presented instruction
if_instr  out  32  presented instruction (NOP 32'h0000_0013 when if_valid=0)
fetch_misalign  out  1  sticky misaligned-redirect flag (see Optional Feature)

Behaviour:
- Reset (async, rst=1):
  - State=BOOT, pc=RESET_PC, buffer empty, outstanding=0, discard=0.
  - imem_req_valid=0, imem_addr=RESET_PC, if_valid=0, if_pc=0, if_instr=NOP, fetch_misalign=0.
- FSM:
  - BOOT: one cycle with no request, then RUN.
  - RUN:
    - Request when outstanding + occupancy < DEPTH; imem_addr=pc.
    - On acceptance (valid & ready), pc += 4 (wraps modulo 2^XLEN) and outstanding++.
  - DRAIN: entered on redirect while outstanding > 0; no requests are issued.
    - Returns to RUN in the cycle after discard reaches 0.
    - A redirect arriving in DRAIN overwrites the target; the discard count is unchanged.
- Response handling:
  - discard>0: drop the response, discard--, outstanding--.
  - Otherwise: push {tag_pc, data}, outstanding--. tag_pc comes from a parallel address FIFO filled at request acceptance.
- Output:
  - Buffer head drives if_pc/if_instr; if_valid = not empty.
  - Pop when if_valid & id_ready.
  - Push and pop in the same cycle are both honoured, so a full buffer with simultaneous pop and push stays full.
- Redirect (highest priority, same cycle):
  - Flush the buffer. if_valid=0 from the next cycle; an output handshake in the redirect cycle is still honoured.
  - pc = redirect_pc with bits [1:0] cleared.
  - discard = outstanding, minus 1 if a response arrives this cycle.
  - A request accepted in the redirect cycle is also counted into discard.
  - Next state: DRAIN if discard > 0, else RUN.
- Redirect during BOOT: target is latched and BOOT still completes.
- Latency: redirect to first new request is 1 cycle (no outstanding); request acceptance to if_valid is memory latency + 1.
- Never overflows: the issue gating guarantees every response has a buffer slot.

Optional Feature:
FETCH_MISALIGN_CHECK_EN
- Defined: a redirect with redirect_pc[1:0] != 0 sets fetch_misalign, which stays set until reset. The address is still aligned down.
- Undefined: fetch_misalign is tied to 0 and low bits are silently cleared.

Decomposition:
- Package fetch_pkg:
  - XLEN default
  - NOP_INSTR = 32'h0000_0013
  - fetch_state_t enum {BOOT, RUN, DRAIN}
  - fetch_entry_t struct {pc, instr}
- Sub-module fetch_buffer: parameterised synchronous FIFO of fetch_entry_t with push/pop/flush/count. Instantiated twice: address tags and the response buffer.

Test Plan:
- Reset, then RESET_PC=0 with 1-cycle-latency memory returning addr+0x100 and id_ready=1 -> requests to 0,4,8,…; if_pc/if_instr = 0/0x100, 4/0x104, … back to back after pipeline fill.
- id_ready=0 for 10 cycles -> at most DEPTH=2 outstanding + buffered; if_valid held with if_pc=0x8 stable; no request issued while full; resumes in order.
- redirect_pc=0x200 with 2 responses in flight -> DRAIN; both stale responses dropped; first new request addr 0x200; next presented if_pc=0x200.
- redirect with outstanding=0 and pop in the same cycle -> popped entry consumed once; next cycle if_valid=0; next request addr=target.
- rst asserted mid-DRAIN with 1 outstanding -> all outputs immediately at reset values; the late response is ignored after reset; fetch restarts at RESET_PC.
- With FETCH_MISALIGN_CHECK_EN: redirect_pc=0x102 -> fetch_misalign=1 (sticky), imem_addr=0x100; without the macro -> flag stays 0.
